// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared constants and types for the Y86 pipeline operand-forwarding logic.
//   RNONE        : register ID meaning "no register"; never forwarded.
//   fwd_slot_e   : default producer slot ordering, youngest producer first.
//   NSRC_DEFAULT : number of producers in the default ordering.
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;

    // Lower index = younger producer = higher forwarding priority.
    typedef enum int {
        SLOT_E_VALE = 0,
        SLOT_M_VALM = 1,
        SLOT_MR_VALE = 2,
        SLOT_W_VALM = 3,
        SLOT_W_VALE = 4
    } fwd_slot_e;

    localparam int NSRC_DEFAULT = 5;

endpackage

// File: rtl/fwd_prio_sel.sv
// ----------------------------------------------------------------------------
// fwd_prio_sel
// Combinational operand selector. Picks the value of the lowest-index enabled
// producer whose destination ID equals the requested source ID; falls back to
// the register-file value when nothing matches, and to zero when the source is
// RNONE.
// Ports:
//   i_src_id  : register ID being read
//   i_rf_val  : register-file value for i_src_id
//   i_fwd_id  : packed producer destination IDs, slot i at [i*IDW +: IDW]
//   i_fwd_val : packed producer values, slot i at [i*WIDTH +: WIDTH]
//   i_fwd_en  : producer slot i writes a register this cycle
//   o_val     : selected operand
//   o_hit     : operand came from a producer
//   o_slot    : winning slot index; NSRC when register file / none
// ----------------------------------------------------------------------------
module fwd_prio_sel
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NSRC  = 5,
    parameter int IDW   = 4,
    parameter int SW    = $clog2(NSRC + 1)
) (
    input  logic [IDW-1:0]        i_src_id,
    input  logic [WIDTH-1:0]      i_rf_val,
    input  logic [NSRC*IDW-1:0]   i_fwd_id,
    input  logic [NSRC*WIDTH-1:0] i_fwd_val,
    input  logic [NSRC-1:0]       i_fwd_en,
    output logic [WIDTH-1:0]      o_val,
    output logic                  o_hit,
    output logic [SW-1:0]         o_slot
);

    logic            w_src_real;
    logic [NSRC-1:0] w_match;

    assign w_src_real = (i_src_id != IDW'(RNONE));

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_match
            assign w_match[gi] = i_fwd_en[gi]
                               & (i_fwd_id[gi*IDW +: IDW] == i_src_id)
                               & w_src_real;
        end
    endgenerate

    // Scan from the highest slot downwards so the lowest matching index is
    // the last assignment and therefore wins.
    always_comb begin
        o_val  = w_src_real ? i_rf_val : '0;
        o_hit  = 1'b0;
        o_slot = SW'(NSRC);
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_val  = i_fwd_val[i*WIDTH +: WIDTH];
                o_hit  = 1'b1;
                o_slot = SW'(i);
            end
        end
    end

endmodule

// File: rtl/operand_forward_mux.sv
// ----------------------------------------------------------------------------
// operand_forward_mux
// Operand-select stage feeding the D->E pipeline register. Chooses a source
// operand from NSRC forwarding producers or the register file (see
// fwd_prio_sel) and registers it with stall/bubble control. Also counts how
// many normal loads took a forwarded value (saturating at 16'hFFFF).
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : D stage holds a real instruction
//   src_id     : register being read
//   rf_val     : register-file value for src_id
//   fwd_id     : packed producer destination IDs
//   fwd_val    : packed producer values
//   fwd_en     : producer slot enables
//   stall      : hold the pipeline register
//   bubble     : load a bubble (takes precedence over stall)
//   out_val    : registered operand
//   out_valid  : registered instruction-valid
//   out_fwd    : registered operand came from a producer
//   out_slot   : registered winning slot (NSRC = register file / none)
//   fwd_count  : saturating count of forwarded loads
// ----------------------------------------------------------------------------
module operand_forward_mux
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NSRC  = NSRC_DEFAULT,
    parameter int IDW   = 4,
    parameter int SW    = $clog2(NSRC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IDW-1:0]        src_id,
    input  logic [WIDTH-1:0]      rf_val,
    input  logic [NSRC*IDW-1:0]   fwd_id,
    input  logic [NSRC*WIDTH-1:0] fwd_val,
    input  logic [NSRC-1:0]       fwd_en,
    input  logic                  stall,
    input  logic                  bubble,
    output logic [WIDTH-1:0]      out_val,
    output logic                  out_valid,
    output logic                  out_fwd,
    output logic [SW-1:0]         out_slot,
    output logic [15:0]           fwd_count
);

    logic [WIDTH-1:0] w_sel_val;
    logic             w_sel_hit;
    logic [SW-1:0]    w_sel_slot;
    logic             w_load_bubble;
    logic             w_load_normal;

    logic [WIDTH-1:0] r_val;
    logic             r_valid;
    logic             r_fwd;
    logic [SW-1:0]    r_slot;
    logic [15:0]      r_fwd_count;

    fwd_prio_sel #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .IDW   (IDW),
        .SW    (SW)
    ) u_sel (
        .i_src_id  (src_id),
        .i_rf_val  (rf_val),
        .i_fwd_id  (fwd_id),
        .i_fwd_val (fwd_val),
        .i_fwd_en  (fwd_en),
        .o_val     (w_sel_val),
        .o_hit     (w_sel_hit),
        .o_slot    (w_sel_slot)
    );

    // Bubble wins over stall; an invalid D-stage instruction also loads a
    // bubble, but only when not stalled.
    assign w_load_bubble = bubble | (~stall & ~in_valid);
    assign w_load_normal = ~bubble & ~stall & in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val   <= '0;
            r_valid <= 1'b0;
            r_fwd   <= 1'b0;
            r_slot  <= SW'(NSRC);
        end else if (w_load_bubble) begin
            r_val   <= '0;
            r_valid <= 1'b0;
            r_fwd   <= 1'b0;
            r_slot  <= SW'(NSRC);
        end else if (w_load_normal) begin
            r_val   <= w_sel_val;
            r_valid <= 1'b1;
            r_fwd   <= w_sel_hit;
            r_slot  <= w_sel_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_count <= 16'h0000;
        end else if (w_load_normal && w_sel_hit && (r_fwd_count != 16'hFFFF)) begin
            r_fwd_count <= r_fwd_count + 16'h0001;
        end
    end

    assign out_val   = r_val;
    assign out_valid = r_valid;
    assign out_fwd   = r_fwd;
    assign out_slot  = r_slot;
    assign fwd_count = r_fwd_count;

endmodule

// File: doc/operand_forward_mux.md
# operand_forward_mux

Parametrised operand-select stage for the pipelined Y86 processor: picks a source operand from N forwarding producers or the register file by destination-ID match with fixed priority, and registers the result into the D→E pipeline register with stall and bubble control. It generalises the fixed 4-way, 2-bit-controlled select to N prioritised sources with automatic match-based selection. It adds registered output, pipeline-control behaviour and a forwarding-hit counter. One instance each serves valA and valB.

## Interface
- WIDTH, 64, operand width in bits
- NSRC, 5, number of forwarding producers
- IDW, 4, register-ID width
- SW, $clog2(NSRC+1), width of slot index (derived; do not override)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  D stage holds a real instruction
- src_id  in  IDW  register being read
- rf_val  in  WIDTH  register-file read value for src_id
- fwd_id  in  NSRC*IDW  producer destination IDs; slot i at bits [i*IDW +: IDW]
- fwd_val  in  NSRC*WIDTH  producer values; slot i at bits [i*WIDTH +: WIDTH]
- fwd_en  in  NSRC  producer slot i is writing a register this cycle
- stall  in  1  hold pipeline register
- bubble  in  1  load bubble into pipeline register
- out_val  out  WIDTH  registered operand
- out_valid  out  1  registered instruction-valid
- out_fwd  out  1  registered operand came from a producer
- out_slot  out  SW  registered winning slot; NSRC = register file / none
- fwd_count  out  16  saturating count of forwarded loads

## Operation
- match[i] = fwd_en[i] & (fwd_id[i] == src_id) & (src_id != RNONE).
- Priority: lowest matching index wins (slot 0 = youngest producer).
- No match: select rf_val, slot NSRC, fwd 0.
- src_id == RNONE: select 0, slot NSRC, fwd 0, regardless of fwd inputs or rf_val.
- Register update each rising edge, in priority order:
  - bubble=1: out_val 0, out_valid 0, out_fwd 0, out_slot NSRC. Bubble overrides stall.
  - stall=1: all outputs hold.
  - in_valid=0: load bubble values as above.
  - Otherwise: load the selection, out_valid 1.
- fwd_count increments by 1 only on a normal load with the forwarded flag set. It saturates at 16'hFFFF and never wraps. It is unaffected by stall or bubble.
- Selection is purely combinational ahead of the register; no state other than the output register and the counter.

## Timing
- Latency: 1 cycle from inputs to out_* on a normal load.
- Asynchronous reset, effective immediately regardless of clk: out_val 0, out_valid 0, out_fwd 0, out_slot NSRC, fwd_count 0.
- Deasserting rst_n mid-stream loses the in-flight operand; the first edge after release is a normal update.
- Stall of k cycles holds outputs k cycles; the first unstalled edge loads current inputs.
- Simultaneous stall and bubble: bubble.
- Duplicate matching slots: lowest index wins; higher slots ignored.

## Structure
- Shared package y86_pkg holds:
  - RNONE = 4'hF.
  - Default slot order: 0 e_valE, 1 m_valM, 2 M_valE, 3 W_valM, 4 W_valE.
- Sub-module fwd_prio_sel (combinational, parametrised WIDTH/NSRC/IDW):
  - Inputs: src_id, rf_val, fwd_*.
  - Outputs: selected value, hit flag, slot index.
- operand_forward_mux wraps fwd_prio_sel with the pipeline register and the counter.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs at reset values, asynchronously; release, src_id=3, rf_val=64'h11, no fwd_en -> next edge out_val 64'h11, out_slot 5, out_fwd 0, out_valid 1.
- Priority: src_id=2, slots 1 and 3 both id 2, enabled, values 64'hAA and 64'hBB -> out_val 64'hAA, out_slot 1, out_fwd 1, fwd_count 1.
- RNONE: src_id=4'hF, slot 0 id 4'hF enabled, value 64'h55 -> out_val 0, out_fwd 0, out_slot 5.
- Stall/bubble: load 64'h77; stall 3 cycles with changing inputs -> out_val stays 64'h77. Then stall and bubble together -> out_val 0, out_valid 0, fwd_count unchanged.
- Counter saturation: preload fwd_count to 16'hFFFE via 65534 forwarded loads (or a force), then 3 more forwarded loads -> stays 16'hFFFF.
- Disabled slot: slot 0 id matches but fwd_en[0]=0, slot 4 matches with 64'h99 -> out_val 64'h99, out_slot 4.
